// File: rtl/z_core_pkg.sv
// Shared Z-Core encodings: opcodes, ALU op codes (common with z_core_alu) and
// the execute-sequencer state encoding.
package z_core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;
  localparam logic [3:0] ALU_BLTU = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } exec_state_t;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/z_core_imm_gen.sv
// Sign-extended RV32I immediates; the opcode field is not needed here.
module z_core_imm_gen
  import z_core_pkg::*;
(
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_u,
  output logic [31:0] imm_b,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/z_core_exec_ctrl.sv
// Multi-cycle RV32I execute sequencer: decode, register read, ALU, write-back.
// state | meaning
// IDLE  | instr_ready high, waiting for fetch handshake
// READ  | rs addresses driven, operands/op latched into ALU registers
// EXEC  | ALU inputs stable, result and branch flag captured
// WB    | rd_we / pc_valid / illegal_instr pulse
module z_core_exec_ctrl
  import z_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  output logic        instr_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_inst_type,
  input  logic [31:0] alu_out,
  input  logic        alu_branch,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        pc_valid,
  output logic [31:0] pc_next,
  output logic        illegal_instr
);

  exec_state_t state, state_nxt;
  logic [31:0] instr_q, pc_q;
  logic [31:0] imm_i, imm_u, imm_b, imm_j;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        dec_illegal, dec_wr, is_jal, is_jalr, is_branch;
  logic [3:0]  dec_op;
  logic [31:0] op_a, op_b, pc4, tgt_sum, target;
  logic        accept;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign f3     = instr_q[14:12];
  assign f7     = instr_q[31:25];
  assign accept = (state == S_IDLE) && instr_valid && instr_ready;

  z_core_imm_gen u_imm_gen (
    .instr (instr_q[31:7]),
    .imm_i (imm_i),
    .imm_u (imm_u),
    .imm_b (imm_b),
    .imm_j (imm_j)
  );

  always_comb begin
    dec_illegal = 1'b1;
    dec_wr      = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    is_branch   = 1'b0;
    dec_op      = ALU_ADD;
    op_a        = 32'd0;
    op_b        = 32'd0;
    case (opcode)
      OPC_OP: begin
        op_a        = rs1_data;
        op_b        = rs2_data;
        dec_op      = alu_op_from_f3(f3, f7[5]);
        dec_wr      = 1'b1;
        dec_illegal = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        op_a        = rs1_data;
        op_b        = ((f3 == 3'b001) || (f3 == 3'b101)) ? {27'd0, imm_i[4:0]} : imm_i;
        dec_op      = alu_op_from_f3(f3, (f3 == 3'b101) && f7[5]);
        dec_wr      = 1'b1;
        dec_illegal = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                      ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      OPC_LUI: begin
        op_b        = imm_u;
        dec_wr      = 1'b1;
        dec_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        op_a        = pc_q;
        op_b        = imm_u;
        dec_wr      = 1'b1;
        dec_illegal = 1'b0;
      end
      OPC_JALR: begin
        op_a        = rs1_data;
        op_b        = imm_i;
        dec_wr      = 1'b1;
        is_jalr     = 1'b1;
        dec_illegal = 1'b0;
      end
      OPC_JAL: begin
        dec_wr      = 1'b1;
        is_jal      = 1'b1;
        dec_illegal = 1'b0;
      end
      OPC_BRANCH: begin
        op_a        = rs1_data;
        op_b        = rs2_data;
        is_branch   = 1'b1;
        dec_illegal = 1'b0;
        case (f3)
          3'b000:  dec_op = ALU_BEQ;
          3'b001:  dec_op = ALU_BNE;
          3'b100:  dec_op = ALU_BLT;
          3'b101:  dec_op = ALU_BGE;
          3'b110:  dec_op = ALU_BLTU;
          3'b111:  dec_op = ALU_BGEU;
          default: dec_illegal = 1'b1;  // funct3 010/011 have no compare op
        endcase
      end
      default: ;
    endcase
  end

  // One shared adder serves both JAL and taken-branch targets.
  assign pc4     = pc_q + 32'd4;
  assign tgt_sum = pc_q + (is_jal ? imm_j : imm_b);

  always_comb begin
    target = pc4;
    if (dec_illegal)                  target = pc4;
    else if (is_jal)                  target = tgt_sum;
    else if (is_jalr)                 target = {alu_out[31:1], 1'b0};
    else if (is_branch && alu_branch) target = tgt_sum;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_READ;
      S_READ: state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_WB;
      S_WB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instr_ready   <= 1'b0;
      instr_q       <= 32'd0;
      pc_q          <= 32'd0;
      rs1_addr      <= 5'd0;
      rs2_addr      <= 5'd0;
      alu_in1       <= 32'd0;
      alu_in2       <= 32'd0;
      alu_inst_type <= 4'd0;
      rd_we         <= 1'b0;
      rd_addr       <= 5'd0;
      rd_data       <= 32'd0;
      pc_valid      <= 1'b0;
      pc_next       <= RESET_PC;
      illegal_instr <= 1'b0;
    end else begin
      instr_ready   <= (state_nxt == S_IDLE);
      rd_we         <= 1'b0;
      pc_valid      <= 1'b0;
      illegal_instr <= 1'b0;
      if (accept) begin
        instr_q  <= instr;
        pc_q     <= instr_pc;
        rs1_addr <= instr[19:15];
        rs2_addr <= instr[24:20];
      end
      if ((state == S_READ) && !dec_illegal && !is_jal) begin
        alu_in1       <= op_a;
        alu_in2       <= op_b;
        alu_inst_type <= dec_op;
      end
      if (state == S_EXEC) begin
        rd_we         <= dec_wr && !dec_illegal && (rd != 5'd0);
        rd_addr       <= rd;
        rd_data       <= (is_jal || is_jalr) ? pc4 : alu_out;
        pc_valid      <= 1'b1;
        pc_next       <= target;
        illegal_instr <= dec_illegal;
      end
    end
  end

endmodule
